// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookups read registered state combinationally; updates land at the rising edge, with no bypass.
module branch_predictor #(
  parameter int WIDTH      = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] f_pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = WIDTH - INDEX_BITS - 2;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [WIDTH-1:0]    target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0]   f_tag, u_tag;
  logic                  f_hit, u_hit;

  assign f_idx = f_pc[INDEX_BITS+1:2];
  assign f_tag = f_pc[WIDTH-1:INDEX_BITS+2];
  assign u_idx = upd_pc[INDEX_BITS+1:2];
  assign u_tag = upd_pc[WIDTH-1:INDEX_BITS+2];

  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign pred_taken  = f_hit && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? target_q[f_idx] : f_pc + WIDTH'(4);

  logic             wr_en;
  logic [1:0]       ctr_d;
  logic [WIDTH-1:0] target_d;

  // A not-taken miss leaves the entry alone so it cannot evict a useful occupant.
  always_comb begin
    wr_en    = 1'b0;
    ctr_d    = ctr_q[u_idx];
    target_d = target_q[u_idx];
    if (upd_valid) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          ctr_d    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
          target_d = upd_target;
        end else begin
          ctr_d    = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        wr_en    = 1'b1;
        ctr_d    = 2'b10;
        target_d = upd_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (wr_en) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= target_d;
      ctr_q[u_idx]    <= ctr_d;
    end
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer with one 2-bit saturating counter per entry. It sits downstream of the execute-stage branch-target adder and consumes its resolved target, outcome and PC. In the same design it is upstream of the fetch PC mux, which it feeds a predicted next PC every cycle.

## Interface

Parameters:
- WIDTH, 32, address/data width
- INDEX_BITS, 6, log2 of entry count (64 entries); tag width is WIDTH-INDEX_BITS-2

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- f_pc  input  WIDTH  current fetch PC
- pred_taken  output  1  prediction: branch at f_pc taken
- pred_target  output  WIDTH  predicted next fetch PC
- upd_valid  input  1  resolved control-flow instruction in execute this cycle
- upd_pc  input  WIDTH  PC of the resolved instruction
- upd_taken  input  1  actual outcome
- upd_target  input  WIDTH  resolved target from the branch-target adder

## Operation

- Index is pc[INDEX_BITS+1:2]; tag is pc[WIDTH-1:INDEX_BITS+2]; pc[1:0] ignored.
- Per-entry state: valid bit, tag, target (WIDTH), 2-bit counter ctr (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Lookup on f_pc:
  - hit = valid[idx] && tag[idx] == f_pc tag.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = target[idx] when pred_taken, else f_pc + 4 (modulo 2^WIDTH, carry discarded).
- Update when upd_valid=1, using upd_pc index/tag:
  - Hit, upd_taken=1: ctr saturating increment (11 stays 11); target overwritten with upd_target.
  - Hit, upd_taken=0: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, upd_taken=1: allocate (evicts any occupant). valid=1, tag written, target=upd_target, ctr=10.
  - Miss, upd_taken=0: no state change; no allocation.
- upd_valid=0: no state change.
- No stall input. The predictor is stateless with respect to fetch; holding f_pc reproduces the same output.

## Timing

- Lookup is combinational from registered state: zero-cycle latency, f_pc to pred_* in the same cycle.
- Updates are written at the rising edge and are visible to lookups starting the next cycle.
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents. There is no write-through bypass.
- Reset, checked at the edge when reset=1:
  - All valid bits are set to 0, all ctr to 01, all targets and tags to 0.
  - Any upd_valid in that cycle is ignored.
  - After reset: pred_taken=0 and pred_target=f_pc+4 for every f_pc.
- Reset asserted mid-operation overrides a concurrent update. The first post-reset cycle behaves identically to power-up.
- Aliasing: two PCs with the same index but different tags evict each other. PCs with the same index and tag share the entry; this is accepted.

## Test plan

- Reset then lookup: assert reset 1 cycle, f_pc=0x0000_1000 -> pred_taken=0, pred_target=0x0000_1004; f_pc=0xFFFF_FFFC -> pred_target=0x0000_0000 (wrap).
- Allocate and hit: update upd_pc=0x100, taken=1, target=0x200. Next cycle f_pc=0x100 -> pred_taken=1, pred_target=0x200. f_pc=0x104 -> pred_taken=0, pred_target=0x108.
- Counter saturation and hysteresis, on allocated 0x100:
  - 3 taken updates leave ctr=11 (predict taken).
  - 1 not-taken update gives ctr=10, still taken.
  - 2nd not-taken gives ctr=01, pred_taken=0, pred_target=0x104.
  - 2 more not-taken give ctr=00; one taken update afterwards gives 01, still not taken.
- Miss not-taken and aliasing:
  - Update 0x300 not-taken -> lookup 0x300 misses.
  - Allocate 0x100 taken. Then allocate 0x100+(4<<INDEX_BITS) taken with target 0x900. Lookup 0x100 now misses and predicts 0x104.
- Same-cycle read/write: f_pc=0x100 and an update allocating 0x100 in the same cycle -> that cycle pred_taken=0; next cycle pred_taken=1.
- Reset mid-operation: populate entries, then assert reset together with upd_valid=1 -> all lookups miss afterward, including the upd_pc of that cycle.
